// File: rtl/text_glyph_renderer.sv
// Beam-synchronous banner renderer: follows the sync generator's pixel counters,
// fetches 8x16 glyph rows for "RED" and serialises them MSB-first into 12-bit RGB.
`timescale 1ns/1ps

module text_glyph_renderer #(
  parameter int          ORIGIN_X = 100,
  parameter int          ORIGIN_Y = 100,
  parameter logic [11:0] FG_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_tick,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [1:0]  font_addr,
  output logic [3:0]  font_row,
  input  logic [7:0]  font_data,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [9:0] X_START = 10'(ORIGIN_X - 2);
  localparam logic [9:0] X_LO    = 10'(ORIGIN_X);
  localparam logic [9:0] X_LAST  = 10'(ORIGIN_X + 23);
  localparam logic [9:0] X_HI    = 10'(ORIGIN_X + 24);
  localparam logic [9:0] Y_LO    = 10'(ORIGIN_Y);
  localparam logic [9:0] Y_HI    = 10'(ORIGIN_Y + 16);

  typedef enum logic [1:0] {IDLE, PREFETCH, RUN} state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [1:0] char_idx;
  logic [9:0] prev_x;

  logic       line_active;
  logic       in_box;
  logic       in_seq;
  logic [3:0] row_lo;
  logic [9:0] glyph_x;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    line_active = (pixel_y >= Y_LO) && (pixel_y < Y_HI);
    in_box      = line_active && (pixel_x >= X_LO) && (pixel_x < X_HI);
    in_seq      = (pixel_x == prev_x + 10'd1);
    row_lo      = 4'(pixel_y - Y_LO);
    glyph_x     = X_LO + {5'd0, char_idx, 3'd0};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; later assignments in the same tick override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      char_idx  <= '0;
      prev_x    <= '0;
      font_addr <= '0;
      font_row  <= '0;
      rgb       <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
    end else if (pixel_tick) begin
      hsync  <= hsync_in;
      vsync  <= vsync_in;
      prev_x <= pixel_x;

      if (!video_on)               rgb <= '0;
      else if (in_box && shreg[7]) rgb <= FG_COLOR;
      else                         rgb <= BG_COLOR;

      case (state)
        IDLE: begin
          font_addr <= '0;
          shreg     <= '0;
          char_idx  <= '0;
          if (line_active && pixel_x == X_START) begin
            font_row <= row_lo;
            state    <= PREFETCH;
          end
        end

        PREFETCH: begin
          if (!in_seq) begin
            shreg <= '0;
            state <= IDLE;
          end else begin
            shreg <= font_data;
            state <= RUN;
          end
        end

        RUN: begin
          if (!in_seq || pixel_x == X_LAST) begin
            // Line wrap, counter jump or end of banner: drop the rest of the row.
            shreg     <= '0;
            font_addr <= '0;
            state     <= IDLE;
          end else begin
            shreg <= shreg << 1;
            if (char_idx != 2'd2 && pixel_x == glyph_x + 10'd6) begin
              font_addr <= char_idx + 2'd1;
              font_row  <= row_lo;
            end
            // Next glyph loads on the same tick the current glyph's last bit is shown.
            if (char_idx != 2'd2 && pixel_x == glyph_x + 10'd7) begin
              shreg    <= font_data;
              char_idx <= char_idx + 2'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
